// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit. It owns the PC, issues word fetches and buffers responses in a prefetch FIFO.
// It redirects on taken branches. Define FETCH_STATS_EN to add the issue/flush statistics counters.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0] stat_issued,
    output logic [15:0] stat_flushed
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    logic [31:0] fetch_pc_q, fetch_pc_d;
    cnt_t        in_flight_q, in_flight_d;
    cnt_t        discard_q, discard_d;

    ptr_t        pcq_rd_q, pcq_rd_d;
    ptr_t        pcq_wr_q, pcq_wr_d;
    logic [31:0] pcq_pc_q [DEPTH];
    logic [31:0] pcq_pc_d [DEPTH];

    cnt_t        fifo_cnt_q, fifo_cnt_d;
    ptr_t        fifo_rd_q, fifo_rd_d;
    ptr_t        fifo_wr_q, fifo_wr_d;
    logic [31:0] fifo_instr_q [DEPTH];
    logic [31:0] fifo_instr_d [DEPTH];
    logic [31:0] fifo_pc_q [DEPTH];
    logic [31:0] fifo_pc_d [DEPTH];

    logic        resp;
    logic        resp_drop;
    logic        push;
    logic        pop;
    logic        issue;
    logic [CW:0] occ;

    // Output side: the FIFO head is the instruction offered to the datapath.
    always_comb begin
        instr_valid = (fifo_cnt_q != '0);
        instr       = '0;
        instr_pc    = '0;
        if (instr_valid) begin
            instr    = fifo_instr_q[fifo_rd_q];
            instr_pc = fifo_pc_q[fifo_rd_q];
        end
    end

    // Occupancy counts the slot freed by this cycle's pop, so a 1-cycle memory streams without bubbles.
    always_comb begin
        resp      = imem_valid && (in_flight_q != '0);
        resp_drop = resp && (discard_q != '0);
        pop       = instr_valid && instr_ready && !redirect;
        push      = resp && !resp_drop && !redirect;
        occ       = {1'b0, in_flight_q} + {1'b0, fifo_cnt_q} - (CW+1)'(pop);
        issue     = rst && !redirect && (occ < DEPTH_C);
        imem_req  = issue;
        imem_addr = fetch_pc_q;
    end

    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        in_flight_d  = in_flight_q + cnt_t'(issue) - cnt_t'(resp);
        discard_d    = discard_q - cnt_t'(resp_drop);
        pcq_rd_d     = pcq_rd_q;
        pcq_wr_d     = pcq_wr_q;
        pcq_pc_d     = pcq_pc_q;
        fifo_cnt_d   = fifo_cnt_q;
        fifo_rd_d    = fifo_rd_q;
        fifo_wr_d    = fifo_wr_q;
        fifo_instr_d = fifo_instr_q;
        fifo_pc_d    = fifo_pc_q;

        if (issue) begin
            fetch_pc_d         = fetch_pc_q + 32'd4;
            pcq_pc_d[pcq_wr_q] = fetch_pc_q;
            pcq_wr_d           = pcq_wr_q + ptr_t'(1);
        end
        // Every accepted response retires one in-flight PC, whether kept or dropped.
        if (resp) begin
            pcq_rd_d = pcq_rd_q + ptr_t'(1);
        end

        if (redirect) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            discard_d  = in_flight_d;
            fifo_cnt_d = '0;
            fifo_rd_d  = '0;
            fifo_wr_d  = '0;
        end else begin
            if (push) begin
                fifo_instr_d[fifo_wr_q] = imem_rdata;
                fifo_pc_d[fifo_wr_q]    = pcq_pc_q[pcq_rd_q];
                fifo_wr_d               = fifo_wr_q + ptr_t'(1);
            end
            if (pop) begin
                fifo_rd_d = fifo_rd_q + ptr_t'(1);
            end
            fifo_cnt_d = fifo_cnt_q + cnt_t'(push) - cnt_t'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q  <= RESET_PC;
            in_flight_q <= '0;
            discard_q   <= '0;
            pcq_rd_q    <= '0;
            pcq_wr_q    <= '0;
            fifo_cnt_q  <= '0;
            fifo_rd_q   <= '0;
            fifo_wr_q   <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            in_flight_q <= in_flight_d;
            discard_q   <= discard_d;
            pcq_rd_q    <= pcq_rd_d;
            pcq_wr_q    <= pcq_wr_d;
            fifo_cnt_q  <= fifo_cnt_d;
            fifo_rd_q   <= fifo_rd_d;
            fifo_wr_q   <= fifo_wr_d;
        end
    end

    // Storage arrays carry no reset; the pointers and counts above decide what is valid.
    always_ff @(posedge clk) begin
        pcq_pc_q     <= pcq_pc_d;
        fifo_instr_q <= fifo_instr_d;
        fifo_pc_q    <= fifo_pc_d;
    end

`ifdef FETCH_STATS_EN
    logic [15:0] stat_issued_q, stat_issued_d;
    logic [15:0] stat_flushed_q, stat_flushed_d;
    logic [CW:0] flush_n;
    logic [16:0] flush_sum;

    // Pending discards were already counted by the redirect that created them.
    always_comb begin
        flush_n        = {1'b0, fifo_cnt_q} + {1'b0, in_flight_q} - {1'b0, discard_q};
        flush_sum      = {1'b0, stat_flushed_q} + 17'(flush_n);
        stat_issued_d  = stat_issued_q;
        stat_flushed_d = stat_flushed_q;
        if (issue && (stat_issued_q != 16'hFFFF)) begin
            stat_issued_d = stat_issued_q + 16'd1;
        end
        if (redirect) begin
            stat_flushed_d = flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_issued_q  <= '0;
            stat_flushed_q <= '0;
        end else begin
            stat_issued_q  <= stat_issued_d;
            stat_flushed_q <= stat_flushed_d;
        end
    end

    assign stat_issued  = stat_issued_q;
    assign stat_flushed = stat_flushed_q;
`endif

endmodule
